// File: rtl/restoring_divider_module.sv
// Sequential restoring divider: one quotient bit per clock via add-of-inverted-divisor trial subtraction.
// Optional macro DIVIDER_SIGNED_EN: two's-complement operands with an extra sign fix-up cycle.
module restoring_divider_module #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dz
);
    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [width:0]   r_r;
    logic [width-1:0] q_r;
    logic [width-1:0] d_r;
    logic [width-1:0] dvd_r;
    logic [width-1:0] quotient_r;
    logic [width-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    logic [width:0]   r_shift_s;
    logic [width+1:0] sum_s;
    logic             carry_s;
    logic [width:0]   r_next_s;
    logic [width-1:0] q_next_s;
    logic             unused_s;

`ifdef DIVIDER_SIGNED_EN
    logic             neg_q_r;
    logic             neg_r_r;

    function automatic logic [width-1:0] mag(input logic [width-1:0] v);
        if (v[width-1]) begin
            mag = ~v + {{(width-1){1'b0}}, 1'b1};
        end else begin
            mag = v;
        end
    endfunction

    function automatic logic [width-1:0] neg_if(input logic n, input logic [width-1:0] v);
        if (n) begin
            neg_if = ~v + {{(width-1){1'b0}}, 1'b1};
        end else begin
            neg_if = v;
        end
    endfunction
`endif

    // Partial remainder stays below the divisor, so its top bit never carries information
    assign unused_s = r_r[width];

    // Trial subtraction: carry-out of R_shifted + ~{0,D} + 1 is set when R_shifted >= D
    always_comb begin
        r_shift_s = {r_r[width-1:0], q_r[width-1]};
        sum_s     = {1'b0, r_shift_s} + {1'b0, ~{1'b0, d_r}} + {{(width+1){1'b0}}, 1'b1};
        carry_s   = sum_s[width+1];
        q_next_s  = {q_r[width-2:0], carry_s};
        if (carry_s) begin
            r_next_s = sum_s[width:0];
        end else begin
            r_next_s = r_shift_s;
        end
    end

    // Control FSM, datapath registers and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            r_r         <= {(width+1){1'b0}};
            q_r         <= {width{1'b0}};
            d_r         <= {width{1'b0}};
            dvd_r       <= {width{1'b0}};
            quotient_r  <= {width{1'b0}};
            remainder_r <= {width{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, FIN: begin
                    if (start) begin
                        r_r     <= {(width+1){1'b0}};
                        dvd_r   <= dividend;
                        count_r <= CW'(width);
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef DIVIDER_SIGNED_EN
                        q_r     <= mag(dividend);
                        d_r     <= mag(divisor);
                        neg_q_r <= dividend[width-1] ^ divisor[width-1];
                        neg_r_r <= dividend[width-1];
`else
                        q_r     <= dividend;
                        d_r     <= divisor;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (d_r == {width{1'b0}}) begin
                        quotient_r  <= {width{1'b1}};
                        remainder_r <= dvd_r;
                        dz_r        <= 1'b1;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= FIN;
                    end else begin
                        r_r     <= r_next_s;
                        q_r     <= q_next_s;
                        count_r <= count_r - CW'(1);
                        if (count_r == CW'(1)) begin
`ifdef DIVIDER_SIGNED_EN
                            state_r     <= FIX;
`else
                            quotient_r  <= q_next_s;
                            remainder_r <= r_next_s[width-1:0];
                            dz_r        <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= FIN;
`endif
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                FIX: begin
`ifdef DIVIDER_SIGNED_EN
                    // Most-negative / -1 wraps naturally: magnitude 2^(w-1) negates to itself
                    quotient_r  <= neg_if(neg_q_r, q_r);
                    remainder_r <= neg_if(neg_r_r, r_r[width-1:0]);
                    dz_r        <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    state_r     <= FIN;
`else
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
`endif
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign dz        = dz_r;

endmodule

// File: doc/restoring_divider_module.md
# restoring_divider_module

Sequential unsigned restoring divider that produces a `width`-bit quotient and remainder, one quotient bit per clock. It is the inverse-operation companion to the team's combinational adder/subtracter. Each iteration performs one trial subtraction as an add of the inverted divisor with carry-in 1, and uses the carry-out to decide whether to restore. It sits in the datapath beside the ALU and is driven by the control unit through a start/busy/done handshake.

## Interface
- `width`, default 4: operand, quotient and remainder width in bits; legal range ≥ 2.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only while `busy`=0.
- `dividend`  input  `width`  numerator; captured on accepted `start`.
- `divisor`  input  `width`  denominator; captured on accepted `start`.
- `quotient`  output  `width`  result; valid from the `done` cycle until the next accepted `start`.
- `remainder`  output  `width`  result; same validity as `quotient`.
- `busy`  output  1  high while iterating.
- `done`  output  1  one-cycle pulse when results become valid.
- `dz`  output  1  divide-by-zero flag; valid with `done`, held with the results.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterating.
  - FIN: one cycle; asserts `done`.
- Reset: state=IDLE; `quotient`, `remainder`, `busy`, `done`, `dz` = 0; internal counter, R and Q registers = 0.
- IDLE or FIN, with `start`=1:
  - Capture operands: Q←`dividend`, D←`divisor`, R←0 (`width`+1 bits).
  - Counter←`width`; go to RUN.
- IDLE or FIN, with `start`=0: FIN→IDLE; IDLE stays.
- RUN, each cycle:
  - Shift: R←{R[`width`-1:0], Q[`width`-1]}, Q←Q<<1.
  - Compute T = R_shifted + ~{0,D} + 1.
  - If the carry-out is 1 (T ≥ 0): R←T and Q[0]←1. Otherwise restore: R unchanged, Q[0]←0.
  - Counter decrements. On the step where the counter reaches 0: go to FIN and register `quotient`←Q, `remainder`←R[`width`-1:0].
- Divide by zero (captured D=0):
  - RUN is skipped: next state is FIN.
  - `quotient`←all ones, `remainder`←`dividend`, `dz`←1.
- `dz`←0 on every accepted non-zero-divisor request.
- `start` while `busy`=1: ignored, with no effect on the operation in flight.
- Operand inputs may change freely after acceptance.
- `rst` mid-operation: the next edge forces IDLE and all outputs to 0. No `done` is produced.
- dividend < divisor → quotient 0, remainder = dividend. dividend = 0 → quotient 0, remainder 0.

## Timing
- `start` accepted at edge k.
- `busy`=1 from edge k through edge k+`width`; iteration steps occur on edges k+1 … k+`width`.
- Edge k+`width`:
  - `busy` falls.
  - `done`=1 for exactly one cycle.
  - `quotient`, `remainder` and `dz` update.
- Latency is `width` cycles from accepted `start` to `done`.
- Divide by zero: `busy`=1 for one cycle only; `done` at edge k+1.
- Back-to-back: `start` held high during the `done` cycle is accepted, so a new `busy` begins at the next edge. Throughput is one result per `width`+1 cycles.
- Results hold stable between `done` and the next accepted `start`, and stay stable through that start's RUN. Outputs change only at the next FIN.

## Configuration
- Macro `DIVIDER_SIGNED_EN`.
- Defined:
  - Operands are two's complement. Magnitudes are divided by the same datapath.
  - Quotient is negated when the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative ÷ −1 yields the most-negative value as quotient (wraps) and remainder 0.
  - Adds one cycle for sign fix-up after RUN, so latency is `width`+1.
- Undefined: unsigned only, with latency `width` as above.

## Test plan
- `width`=4, 13÷3: start at edge k → `done` at edge k+4, quotient 4, remainder 1, `dz`=0.
- 5÷9 → quotient 0, remainder 5; 15÷1 → quotient 15, remainder 0; 0÷7 → quotient 0, remainder 0.
- 6÷0 → `done` at edge k+1, quotient 4'hF, remainder 6, `dz`=1. A following 8÷2 gives quotient 4, remainder 0, `dz`=0.
- `start` with 9÷2, then `start` pulsed with 7÷7 at edge k+2 → the second start is ignored; result quotient 4, remainder 1 at edge k+4.
- `rst` asserted at edge k+2 of 14÷3 → all outputs 0 at the next edge, no `done`. A new 14÷3 then gives quotient 4, remainder 2.
- `DIVIDER_SIGNED_EN` defined: −7÷2 → quotient −3 (4'hD), remainder −1 (4'hF), latency 5. −8÷−1 → quotient 4'h8, remainder 0.
